// File: rtl/cve2_pkg.sv
// Shared types for the ID-side execute issue controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cve2_pkg;

   // M-extension implementation variants; RV32MNone removes all multdiv issue.
   typedef enum integer {
      RV32MNone        = 0,
      RV32MSlow        = 1,
      RV32MFast        = 2,
      RV32MSingleCycle = 3
   } rv32m_e;

   // Issue FSM: first execute cycle of an instruction, or a later cycle of a
   // multi-cycle operation.
   typedef enum logic [0:0] {
      ExIssueFirst = 1'b0,
      ExIssueMulti = 1'b1
   } ex_issue_state_e;

   localparam int unsigned ImdValW = 34;
   localparam int unsigned ExCntW  = 6;

   // Saturating increment: the cycle counter must never wrap back to a
   // value that looks like a fresh operation.
   function automatic logic [ExCntW-1:0] ex_cnt_inc(input logic [ExCntW-1:0] c);
      return (&c) ? c : c + ExCntW'(1);
   endfunction

endpackage

// File: rtl/cve2_imd_val_regs.sv
// Two 34-bit intermediate-value registers written back by the execution block.
// Latency: write visible on q outputs one cycle after we_i.
// Backpressure: none; clr_i has priority over any write.
// Ports: clk_i/rst_i clock and sync reset, clr_i clears both registers,
//        we_i per-register write enable, d0_i/d1_i write data, q0_o/q1_o contents.
module cve2_imd_val_regs
   import cve2_pkg::*;
(
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               clr_i,
   input  logic [1:0]         we_i,
   input  logic [ImdValW-1:0] d0_i,
   input  logic [ImdValW-1:0] d1_i,
   output logic [ImdValW-1:0] q0_o,
   output logic [ImdValW-1:0] q1_o
);

   logic [ImdValW-1:0] q0_q, q0_d;
   logic [ImdValW-1:0] q1_q, q1_d;

   always_comb begin
      q0_d = q0_q;
      q1_d = q1_q;
      if (clr_i) begin
         q0_d = '0;
         q1_d = '0;
      end else begin
         if (we_i[0]) q0_d = d0_i;
         if (we_i[1]) q1_d = d1_i;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         q0_q <= '0;
         q1_q <= '0;
      end else begin
         q0_q <= q0_d;
         q1_q <= q1_d;
      end
   end

   assign q0_o = q0_q;
   assign q1_o = q1_q;

endmodule

// File: rtl/cve2_ex_issue_ctrl.sv
// Issues decoded instructions to the execution block, stalls ID during
// multi-cycle ops, owns the intermediate-value registers and registers writeback.
// Latency: single-cycle ops complete with 0 stall cycles; writeback 1 cycle
// after ex_valid_i. Backpressure: stall_o holds ID until ex_valid_i, flush or abort.
// Ports: instr_valid_i/flush_i issue control; *_dec_i decoder info;
//        ex_valid_i/result_ex_i execution result; imd_val_* intermediate regs;
//        mult/div en/sel to multdiv; stall_o/instr_done_o to ID;
//        rf_* registered writeback; timeout_o watchdog abort pulse.
module cve2_ex_issue_ctrl
   import cve2_pkg::*;
#(
   parameter rv32m_e      RV32M             = RV32MFast,
   parameter int unsigned MultiCycleTimeout = 40
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               instr_valid_i,
   input  logic               flush_i,
   input  logic               mult_sel_dec_i,
   input  logic               div_sel_dec_i,
   input  logic               rf_we_dec_i,
   input  logic [4:0]         rf_waddr_dec_i,
   input  logic               ex_valid_i,
   input  logic [31:0]        result_ex_i,
   input  logic [1:0]         imd_val_we_i,
   input  logic [ImdValW-1:0] imd_val_d0_i,
   input  logic [ImdValW-1:0] imd_val_d1_i,
   output logic [ImdValW-1:0] imd_val_q0_o,
   output logic [ImdValW-1:0] imd_val_q1_o,
   output logic               mult_en_o,
   output logic               div_en_o,
   output logic               mult_sel_o,
   output logic               div_sel_o,
   output logic               alu_instr_first_cycle_o,
   output logic               stall_o,
   output logic               instr_done_o,
   output logic               rf_we_o,
   output logic [4:0]         rf_waddr_o,
   output logic [31:0]        rf_wdata_o,
   output logic               timeout_o
);

   localparam bit                MdEn    = (RV32M != RV32MNone);
   localparam logic [ExCntW-1:0] CntLast = ExCntW'(MultiCycleTimeout - 1);

   ex_issue_state_e   state_q, state_d;
   logic [ExCntW-1:0] cnt_q, cnt_d;
   logic              timeout_q, timeout_d;
   logic              rf_we_q, rf_we_d;
   logic [4:0]        rf_waddr_q, rf_waddr_d;
   logic [31:0]       rf_wdata_q, rf_wdata_d;

   logic abort;
   logic done;

   // Watchdog: last permitted Multi cycle passes without a result.
   assign abort = (state_q == ExIssueMulti) & (cnt_q == CntLast) & ~ex_valid_i;
   assign done  = instr_valid_i & ex_valid_i & ~flush_i;

   assign mult_sel_o              = MdEn & instr_valid_i & mult_sel_dec_i;
   assign div_sel_o               = MdEn & instr_valid_i & div_sel_dec_i;
   assign mult_en_o               = mult_sel_o & ~flush_i & ~abort;
   assign div_en_o                = div_sel_o & ~flush_i & ~abort;
   assign alu_instr_first_cycle_o = instr_valid_i & (state_q == ExIssueFirst);
   assign instr_done_o            = done;
   assign stall_o                 = instr_valid_i & ~ex_valid_i & ~flush_i & ~abort;

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      timeout_d  = abort;
      rf_we_d    = 1'b0;
      rf_waddr_d = rf_waddr_q;
      rf_wdata_d = rf_wdata_q;

      unique case (state_q)
         ExIssueFirst: begin
            cnt_d = '0;
            if (instr_valid_i & ~flush_i & ~ex_valid_i) begin
               state_d = ExIssueMulti;
               cnt_d   = ExCntW'(1);
            end
         end
         ExIssueMulti: begin
            // Losing instr_valid_i mid-operation is treated as a kill.
            if (~instr_valid_i | flush_i | ex_valid_i | abort) begin
               state_d = ExIssueFirst;
               cnt_d   = '0;
            end else begin
               cnt_d = ex_cnt_inc(cnt_q);
            end
         end
         default: begin
            state_d = ExIssueFirst;
            cnt_d   = '0;
         end
      endcase

      if (done) begin
         rf_we_d    = rf_we_dec_i;
         rf_waddr_d = rf_waddr_dec_i;
         rf_wdata_d = result_ex_i;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= ExIssueFirst;
         cnt_q      <= '0;
         timeout_q  <= 1'b0;
         rf_we_q    <= 1'b0;
         rf_waddr_q <= '0;
         rf_wdata_q <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         timeout_q  <= timeout_d;
         rf_we_q    <= rf_we_d;
         rf_waddr_q <= rf_waddr_d;
         rf_wdata_q <= rf_wdata_d;
      end
   end

   assign timeout_o  = timeout_q;
   assign rf_we_o    = rf_we_q;
   assign rf_waddr_o = rf_waddr_q;
   assign rf_wdata_o = rf_wdata_q;

   cve2_imd_val_regs u_imd_val_regs (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .clr_i (flush_i | abort),
      .we_i  (imd_val_we_i),
      .d0_i  (imd_val_d0_i),
      .d1_i  (imd_val_d1_i),
      .q0_o  (imd_val_q0_o),
      .q1_o  (imd_val_q1_o)
   );

endmodule

// File: tb/tb_cve2_ex_issue_ctrl.sv
module tb_cve2_ex_issue_ctrl;
   import cve2_pkg::*;

   localparam int TO = 40;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, iv, flush, mdec, ddec, wedec, exv;
   logic [4:0]  rd;
   logic [31:0] res;
   logic [1:0]  ivwe;
   logic [33:0] d0, d1;

   logic [33:0] q0, q1, nq0, nq1;
   logic mul_en, div_en, mul_sel, div_sel, first, stall, done, rfwe, tmo;
   logic [4:0]  waddr;
   logic [31:0] wdata;
   logic n_mul_en, n_div_en, n_mul_sel, n_div_sel, n_first, n_stall, n_done, n_rfwe, n_tmo;
   logic [4:0]  n_waddr;
   logic [31:0] n_wdata;

   cve2_ex_issue_ctrl #(.RV32M(RV32MFast), .MultiCycleTimeout(TO)) u_dut (
      .clk_i(clk), .rst_i(rst), .instr_valid_i(iv), .flush_i(flush),
      .mult_sel_dec_i(mdec), .div_sel_dec_i(ddec), .rf_we_dec_i(wedec),
      .rf_waddr_dec_i(rd), .ex_valid_i(exv), .result_ex_i(res),
      .imd_val_we_i(ivwe), .imd_val_d0_i(d0), .imd_val_d1_i(d1),
      .imd_val_q0_o(q0), .imd_val_q1_o(q1),
      .mult_en_o(mul_en), .div_en_o(div_en), .mult_sel_o(mul_sel), .div_sel_o(div_sel),
      .alu_instr_first_cycle_o(first), .stall_o(stall), .instr_done_o(done),
      .rf_we_o(rfwe), .rf_waddr_o(waddr), .rf_wdata_o(wdata), .timeout_o(tmo));

   cve2_ex_issue_ctrl #(.RV32M(RV32MNone), .MultiCycleTimeout(TO)) u_none (
      .clk_i(clk), .rst_i(rst), .instr_valid_i(iv), .flush_i(flush),
      .mult_sel_dec_i(mdec), .div_sel_dec_i(ddec), .rf_we_dec_i(wedec),
      .rf_waddr_dec_i(rd), .ex_valid_i(exv), .result_ex_i(res),
      .imd_val_we_i(ivwe), .imd_val_d0_i(d0), .imd_val_d1_i(d1),
      .imd_val_q0_o(nq0), .imd_val_q1_o(nq1),
      .mult_en_o(n_mul_en), .div_en_o(n_div_en), .mult_sel_o(n_mul_sel), .div_sel_o(n_div_sel),
      .alu_instr_first_cycle_o(n_first), .stall_o(n_stall), .instr_done_o(n_done),
      .rf_we_o(n_rfwe), .rf_waddr_o(n_waddr), .rf_wdata_o(n_wdata), .timeout_o(n_tmo));

   int n_cmp = 0;
   int n_err = 0;

   // Reference model: "age" is how many cycles the current instruction has
   // already spent executing (0 = its first execute cycle).
   int          m_age = 0;
   logic [33:0] m_q0 = '0, m_q1 = '0;
   logic        m_rfwe = 1'b0, m_tmo = 1'b0;
   logic [4:0]  m_waddr = '0;
   logic [31:0] m_wdata = '0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock: check combinational outputs against the model, clock, then
   // advance the model and check the registered outputs.
   task automatic step(input bit chk_comb);
      bit timed_out, fin, kill;
      #1;
      timed_out = (m_age == TO - 1) && !exv;
      fin  = iv && exv && !flush;
      kill = flush || timed_out;
      if (chk_comb) begin
         chk("mult_sel", mul_sel, iv & mdec);
         chk("div_sel",  div_sel, iv & ddec);
         chk("mult_en",  mul_en,  iv & mdec & !kill);
         chk("div_en",   div_en,  iv & ddec & !kill);
         chk("first",    first,   iv && (m_age == 0));
         chk("done",     done,    fin);
         chk("stall",    stall,   iv && !exv && !kill);
         chk("none_sel", {n_mul_sel, n_div_sel, n_mul_en, n_div_en}, 0);
      end
      @(posedge clk);
      if (rst) begin
         m_age = 0; m_q0 = '0; m_q1 = '0;
         m_rfwe = 0; m_waddr = '0; m_wdata = '0; m_tmo = 0;
      end else begin
         m_tmo  = timed_out;
         m_rfwe = fin && wedec;
         if (fin) begin m_waddr = rd; m_wdata = res; end
         if (kill) begin m_q0 = '0; m_q1 = '0; end
         else begin
            if (ivwe[0]) m_q0 = d0;
            if (ivwe[1]) m_q1 = d1;
         end
         if (m_age == 0) m_age = (iv && !flush && !exv) ? 1 : 0;
         else if (!iv || kill || exv) m_age = 0;
         else if (m_age < 63) m_age++;
      end
      #1;
      chk("rf_we",    rfwe,  m_rfwe);
      chk("rf_waddr", waddr, m_waddr);
      chk("rf_wdata", wdata, m_wdata);
      chk("timeout",  tmo,   m_tmo);
      chk("imd_q0",   q0,    m_q0);
      chk("imd_q1",   q1,    m_q1);
   endtask

   task automatic idle();
      iv = 0; flush = 0; mdec = 0; ddec = 0; wedec = 0; exv = 0; ivwe = 0; rst = 0;
   endtask

   initial begin
      idle(); rd = 0; res = 0; d0 = 0; d1 = 0;
      rst = 1;
      step(0);
      chk("reset_rf_we", rfwe, 0);
      step(1);
      rst = 0;
      step(1);

      // ADD, single cycle
      iv = 1; wedec = 1; rd = 7; res = 32'h5; exv = 1;
      step(1);
      chk("add_wb", {27'd0, rfwe, waddr, wdata}, {27'd0, 1'b1, 5'd7, 32'h5});
      idle(); step(1);

      // DIV, result after 37 stall cycles
      iv = 1; ddec = 1; wedec = 1; rd = 3; res = 32'hFFFF_FFFD;
      for (int k = 0; k < 38; k++) begin
         exv = (k == 37);
         step(1);
      end
      chk("div_wb", {27'd0, rfwe, waddr, wdata}, {27'd0, 1'b1, 5'd3, 32'hFFFF_FFFD});
      idle(); step(1);

      // MUL with intermediate writes, then flush
      iv = 1; mdec = 1; wedec = 1; rd = 9; ivwe = 2'b11;
      d0 = 34'h3_0000_0001; d1 = 34'h1_2345_6789;
      step(1);
      chk("imd_q0_val", q0, 34'h3_0000_0001);
      chk("imd_q1_val", q1, 34'h1_2345_6789);
      ivwe = 0; flush = 1;
      step(1);
      chk("flush_clr", {q0, q1}, 0);
      idle(); step(1);

      // flush and ex_valid together
      iv = 1; mdec = 1; wedec = 1; rd = 12; res = 32'hDEAD_BEEF;
      step(1);
      flush = 1; exv = 1;
      step(1);
      chk("flush_vs_exv_we", rfwe, 0);
      idle(); step(1);

      // watchdog timeout
      iv = 1; ddec = 1; wedec = 1; ivwe = 2'b01; d0 = 34'h2_AAAA_5555;
      for (int k = 0; k < TO; k++) step(1);
      chk("timeout_pulse", tmo, 1);
      idle(); step(1);
      chk("timeout_one_shot", tmo, 0);

      // reset mid-Multi
      iv = 1; mdec = 1; wedec = 1; rd = 21; res = 32'h1234; exv = 1;
      step(1);
      exv = 0; ivwe = 2'b10; d1 = 34'h3_FFFF_0000;
      for (int k = 0; k < 5; k++) step(1);
      rst = 1;
      step(1);
      chk("rst_mid_regs", {rfwe, waddr, wdata, tmo}, 0);
      chk("rst_mid_imd", {q0, q1}, 0);
      idle(); step(1);

      // randomized traffic
      for (int k = 0; k < 1500; k++) begin
         iv    = ($urandom_range(0, 9) != 0);
         flush = ($urandom_range(0, 29) == 0);
         exv   = ($urandom_range(0, (k < 750) ? 3 : 60) == 0);
         rst   = ($urandom_range(0, 199) == 0);
         mdec  = $urandom_range(0, 1);
         ddec  = !mdec && ($urandom_range(0, 1) == 1);
         wedec = $urandom_range(0, 1);
         rd    = 5'($urandom_range(0, 31));
         res   = $urandom;
         ivwe  = 2'($urandom_range(0, 3));
         d0    = {2'($urandom_range(0, 3)), 32'($urandom)};
         d1    = {2'($urandom_range(0, 3)), 32'($urandom)};
         step(1);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
